// File: rtl/adder_scheduler_pkg.sv
// Shared definitions for the adder scheduler: operand width, FSM state
// encodings and requester ids.
package adder_scheduler_pkg;

  localparam int WIDTH = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the building block of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_adder17.sv
// Purely combinational ripple-carry adder built from full_adder cells;
// carry-in is fixed at zero.
module ripple_adder17 #(
  parameter int WIDTH = adder_scheduler_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/adder_scheduler.sv
// Round-robin sequencer sharing one registered ripple-carry adder between two
// valid/ready requesters; results are held until the consumer accepts them.
module adder_scheduler #(
  parameter int WIDTH = adder_scheduler_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH:0]   res_sum,
  output logic             res_id,
  input  logic             res_ready
);

  import adder_scheduler_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_id;
  logic             last_grant;
  logic             grant;
  logic             accept_ok;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // NOTE: grant gets a default before any branch so always_comb can never
  // infer a latch for the paths that do not assign it.
  always_comb begin
    grant = REQ0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = REQ1;
  end

  // No acceptance while reset is asserted, so no handshake is ever lost to it.
  assign accept_ok  = (state == ST_IDLE) && !reset;
  assign req0_ready = accept_ok && req0_valid && (grant == REQ0);
  assign req1_ready = accept_ok && req1_valid && (grant == REQ1);

  // The adder sees only registered operands: the whole carry chain gets a
  // full cycle between op_a/op_b and res_sum.
  ripple_adder17 #(.WIDTH(WIDTH)) u_adder (
    .a    (op_a),
    .b    (op_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= REQ0;
      last_grant <= REQ1;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_id     <= REQ0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0_valid && req0_ready) begin
            op_a       <= req0_a;
            op_b       <= req0_b;
            op_id      <= REQ0;
            last_grant <= REQ0;
            state      <= ST_ADD;
          end else if (req1_valid && req1_ready) begin
            op_a       <= req1_a;
            op_b       <= req1_b;
            op_id      <= REQ1;
            last_grant <= REQ1;
            state      <= ST_ADD;
          end
        end
        ST_ADD: begin
          res_sum   <= {add_cout, add_sum};
          res_id    <= op_id;
          res_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_scheduler.sv
// Self-checking bench for adder_scheduler: vector table, scoreboard of
// accepted pairs, and directed sequences for arbitration, backpressure and reset.
module tb_adder_scheduler;

  import adder_scheduler_pkg::*;

  localparam int W = 17;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         res_valid;
  logic [W:0]   res_sum;
  logic         res_id;
  logic         res_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_scheduler #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_sum    (res_sum),
    .res_id     (res_id),
    .res_ready  (res_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on every observed handshake, pop on every accepted result.
  typedef struct {
    logic       id;
    logic [W:0] sum;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (req0_valid && req0_ready) sb.push_back('{REQ0, {1'b0, req0_a} + {1'b0, req0_b}});
      if (req1_valid && req1_ready) sb.push_back('{REQ1, {1'b0, req1_a} + {1'b0, req1_b}});
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_result", 32'(res_sum), 32'hFFFF_FFFF);
        end else begin
          sb_e = sb.pop_front();
          check("sb_sum", 32'(res_sum), 32'(sb_e.sum));
          check("sb_id", 32'(res_id), 32'(sb_e.id));
        end
      end
    end
  end

  task automatic drive_req(input logic id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == REQ0) begin
      req0_valid = v; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b;
    end
  endtask

  // Bounded wait for the given requester's ready, sampled at the falling edge.
  task automatic wait_ready(input logic id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((id == REQ0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // One addition with res_ready high: checks the 2-edge latency and the result.
  task automatic apply_single(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W:0] exp_sum);
    bit ok;
    @(posedge clk); #1;
    res_ready = 1'b1;
    drive_req(id, 1'b1, a, b);
    wait_ready(id, ok);
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    drive_req(id, 1'b0, '0, '0);
    @(negedge clk);
    check("latency_add_no_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(res_valid), 32'd1);
    check("vec_sum", 32'(res_sum), 32'(exp_sum));
    check("vec_id", 32'(res_id), 32'(id));
  endtask

  typedef struct {
    logic       id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0] exp_sum;
  } vec_t;

  vec_t vecs[6];
  int   g_id[4];
  int   g_t[4];
  int   ngr;
  int   cyc;
  int   pulses;
  bit   ok;
  logic [W:0] held;

  initial begin
    vecs[0] = '{REQ0, 17'h00005, 17'h00003, 18'h00008};
    vecs[1] = '{REQ1, 17'h1FFFF, 17'h1FFFF, 18'h3FFFE};
    vecs[2] = '{REQ1, 17'h1FFFF, 17'h00001, 18'h20000};
    vecs[3] = '{REQ0, 17'h00000, 17'h00000, 18'h00000};
    vecs[4] = '{REQ0, 17'h12345, 17'h0ABCD, 18'h1CF12};
    vecs[5] = '{REQ1, 17'h15555, 17'h0AAAA, 18'h1FFFF};

    // Reset held 2 cycles with both requesters valid.
    reset = 1'b1; res_ready = 1'b0;
    drive_req(REQ0, 1'b1, 17'h00011, 17'h00022);
    drive_req(REQ1, 1'b1, 17'h00033, 17'h00044);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset_req0_ready", 32'(req0_ready), 32'd0);
    check("reset_req1_ready", 32'(req1_ready), 32'd0);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_sum", 32'(res_sum), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post_reset_req0_ready", 32'(req0_ready), 32'd1);
    check("post_reset_req1_ready", 32'(req1_ready), 32'd0);
    drive_req(REQ0, 1'b0, '0, '0);
    drive_req(REQ1, 1'b0, '0, '0);

    // Vector table, one requester at a time.
    for (int i = 0; i < 6; i++) apply_single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_sum);

    // Round-robin: both valid continuously, fresh operands after each grant.
    @(posedge clk); #1;
    res_ready = 1'b1;
    drive_req(REQ0, 1'b1, 17'h00100, 17'h00001);
    drive_req(REQ1, 1'b1, 17'h00200, 17'h00002);
    ngr = 0; cyc = 0;
    for (int k = 0; k < 40 && ngr < 4; k++) begin
      @(negedge clk);
      ok = 1'b0;
      if (req0_ready) begin g_id[ngr] = 0; g_t[ngr] = cyc; ngr++; ok = 1'b1; end
      else if (req1_ready) begin g_id[ngr] = 1; g_t[ngr] = cyc; ngr++; ok = 1'b1; end
      cyc++;
      @(posedge clk); #1;
      if (ngr == 4) begin
        drive_req(REQ0, 1'b0, '0, '0);
        drive_req(REQ1, 1'b0, '0, '0);
      end else if (ok && g_id[ngr-1] == 0) begin
        drive_req(REQ0, 1'b1, 17'(17'h00100 + ngr * 17'h00111), 17'(17'h00001 + ngr));
      end else if (ok) begin
        drive_req(REQ1, 1'b1, 17'(17'h00200 + ngr * 17'h00222), 17'(17'h00002 + ngr));
      end
    end
    check("rr_grant_count", 32'(ngr), 32'd4);
    for (int i = 0; i < ngr; i++) check("rr_order", 32'(g_id[i]), 32'(i % 2));
    for (int i = 1; i < ngr; i++) check("rr_spacing", 32'(g_t[i] - g_t[i-1]), 32'd3);
    repeat (4) @(negedge clk);

    // Backpressure: hold the result for 5 cycles with another request pending.
    @(posedge clk); #1;
    res_ready = 1'b0;
    drive_req(REQ0, 1'b1, 17'h00100, 17'h00023);
    wait_ready(REQ0, ok);
    if (!ok) check("bp_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    drive_req(REQ0, 1'b0, '0, '0);
    drive_req(REQ1, 1'b1, 17'h00007, 17'h00009);
    @(negedge clk);
    @(negedge clk);
    check("bp_valid", 32'(res_valid), 32'd1);
    check("bp_sum", 32'(res_sum), 32'h123);
    held = res_sum;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(res_valid), 32'd1);
      check("bp_hold_sum", 32'(res_sum), 32'(held));
      check("bp_hold_req0_ready", 32'(req0_ready), 32'd0);
      check("bp_hold_req1_ready", 32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", 32'(res_valid), 32'd0);
    check("bp_next_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    drive_req(REQ1, 1'b0, '0, '0);
    @(negedge clk);
    check("bp_next_accepted", 32'(req1_ready), 32'd0);
    repeat (3) @(negedge clk);

    // Mid-operation reset: last_grant would favour req1 without it.
    apply_single(REQ0, 17'h00001, 17'h00002, 18'h00003);
    @(posedge clk); #1;
    drive_req(REQ0, 1'b1, 17'h00055, 17'h00011);
    wait_ready(REQ0, ok);
    if (!ok) check("mid_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    drive_req(REQ0, 1'b0, '0, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    check("mid_reset_no_result", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    drive_req(REQ0, 1'b1, 17'h00001, 17'h00001);
    drive_req(REQ1, 1'b1, 17'h00002, 17'h00002);
    #1;
    check("mid_reset_tie_req0", 32'(req0_ready), 32'd1);
    check("mid_reset_tie_req1", 32'(req1_ready), 32'd0);
    drive_req(REQ0, 1'b0, '0, '0);
    drive_req(REQ1, 1'b0, '0, '0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
